// File: rtl/add_path_arbiter_if.sv
// add_path_arbiter_if
//   Bundles the requester-facing and datapath-facing signals of
//   add_path_arbiter.
//   master : arbiter view (drives grants, results and the datapath controls)
//   slave  : environment view (requesters plus the Add_Path datapath)
//   Requester side : req[1:0], sign0/1, mat_A0/B0/A1/B1 (64b),
//                    gnt[1:0], done[1:0], result (160b), err
//   Datapath side  : path_mat_A/B (64b), path_sign, path_add_en, path_rst,
//                    path_mat_out (160b), path_finish
interface add_path_arbiter_if;
   logic [1:0]   req;
   logic         sign0;
   logic         sign1;
   logic [63:0]  mat_A0;
   logic [63:0]  mat_B0;
   logic [63:0]  mat_A1;
   logic [63:0]  mat_B1;
   logic [1:0]   gnt;
   logic [1:0]   done;
   logic [159:0] result;
   logic         err;
   logic [63:0]  path_mat_A;
   logic [63:0]  path_mat_B;
   logic         path_sign;
   logic         path_add_en;
   logic         path_rst;
   logic [159:0] path_mat_out;
   logic         path_finish;

   modport master (
      input  req, sign0, sign1, mat_A0, mat_B0, mat_A1, mat_B1,
      input  path_mat_out, path_finish,
      output gnt, done, result, err,
      output path_mat_A, path_mat_B, path_sign, path_add_en, path_rst
   );

   modport slave (
      output req, sign0, sign1, mat_A0, mat_B0, mat_A1, mat_B1,
      output path_mat_out, path_finish,
      input  gnt, done, result, err,
      input  path_mat_A, path_mat_B, path_sign, path_add_en, path_rst
   );
endinterface

// File: rtl/add_path_arbiter.sv
// add_path_arbiter
//   Shares one Add_Path 4x4 matrix add/subtract datapath between two
//   requesters. Round-robin arbitration, operand/sign latching, datapath
//   clear + start, wait for finish, result capture and a one-cycle done.
//
//   Ports:
//     clk  : sole clock, rising edge
//     rst  : synchronous reset, active-low
//     bus  : add_path_arbiter_if.master (requester and datapath signals)
//
//   Parameter:
//     TIMEOUT_CYCLES : WAIT cycles before abort (only with the timeout build)
//
//   Build option:
//     ADD_ARB_TIMEOUT_EN : when defined, a WAIT down-counter aborts a stuck
//                          operation with done + err; otherwise WAIT holds
//                          until path_finish and err is tied low.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | sample req, pick winner, latch its operands and sign
//   CLR   | path_rst high for one cycle, grant asserted
//   START | path_add_en high for one cycle
//   WAIT  | wait for path_finish, capture path_mat_out
//   DONE  | done pulse to winner, update round-robin pointer
module add_path_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst,
   add_path_arbiter_if.master  bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic          pick;
   logic          winner_q;
   logic          last_gnt_q;
   logic [63:0]   path_a_q;
   logic [63:0]   path_b_q;
   logic          path_sign_q;
   logic [159:0]  result_q;
   logic          wait_abort;
   logic [1:0]    winner_onehot;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef ADD_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             timed_out_q;

   // Loaded in START so the first WAIT cycle sees TIMEOUT_CYCLES-1; the
   // terminal count is therefore reached in the last allowed WAIT cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt_q   <= '0;
         timed_out_q <= 1'b0;
      end else if (state_q == ST_START) begin
         tmo_cnt_q   <= TMO_W'(TIMEOUT_CYCLES - 1);
         timed_out_q <= 1'b0;
      end else if (state_q == ST_WAIT) begin
         if (!bus.path_finish && (tmo_cnt_q == '0)) begin
            timed_out_q <= 1'b1;
         end else begin
            tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
         end
      end
   end

   // finish has priority over the terminal count
   assign wait_abort = (tmo_cnt_q == '0) && !bus.path_finish;
   assign bus.err    = (state_q == ST_DONE) && timed_out_q;
`else
   assign wait_abort = 1'b0;
   assign bus.err    = 1'b0;
`endif

   // Single request wins outright; on a tie the side not served last wins.
   always_comb begin
      pick = 1'b0;
      case (bus.req)
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last_gnt_q;
         default: pick = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (|bus.req) state_d = ST_CLR;
         ST_CLR:   state_d = ST_START;
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  if (bus.path_finish || wait_abort) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         winner_q    <= 1'b0;
         last_gnt_q  <= 1'b1;
         path_a_q    <= '0;
         path_b_q    <= '0;
         path_sign_q <= 1'b0;
         result_q    <= '0;
      end else begin
         if ((state_q == ST_IDLE) && (|bus.req)) begin
            winner_q    <= pick;
            path_a_q    <= pick ? bus.mat_A1 : bus.mat_A0;
            path_b_q    <= pick ? bus.mat_B1 : bus.mat_B0;
            path_sign_q <= pick ? bus.sign1  : bus.sign0;
         end
         if ((state_q == ST_WAIT) && bus.path_finish) begin
            result_q <= bus.path_mat_out;
         end
         if (state_q == ST_DONE) begin
            last_gnt_q <= winner_q;
         end
      end
   end

   assign winner_onehot   = winner_q ? 2'b10 : 2'b01;
   assign bus.gnt         = (state_q != ST_IDLE) ? winner_onehot : 2'b00;
   assign bus.done        = (state_q == ST_DONE) ? winner_onehot : 2'b00;
   assign bus.result      = result_q;
   assign bus.path_mat_A  = path_a_q;
   assign bus.path_mat_B  = path_b_q;
   assign bus.path_sign   = path_sign_q;
   assign bus.path_add_en = (state_q == ST_START);
   // Keep the datapath in reset for as long as the arbiter itself is.
   assign bus.path_rst    = ~rst | (state_q == ST_CLR);

endmodule
